rp_result_checker: RTL and testbench

//  Parametrised self-checking comparator for the djbcodec encode/decode benches and FPGA test shells.

---
 rtl/rp_result_checker_if.sv | 31 +++
 rtl/rp_result_checker.sv | 133 +++++++++++++
 tb/tb_rp_result_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rp_result_checker_if.sv
// Checker control, memory read port and result bus shared between the checker (slave) and its driver (master).
// The master side owns start/config and the two read-data returns; the slave side owns address and results.
interface rp_result_checker_if #(
  parameter int D_SIZE  = 16,
  parameter int Q_DEPTH = 10,
  parameter int CNT_W   = 12
);
  logic               start;
  logic [Q_DEPTH-1:0] addr_max;
  logic [7:0]         passes;
  logic [Q_DEPTH-1:0] rd_addr;
  logic [D_SIZE-1:0]  rd_data_dut;
  logic [D_SIZE-1:0]  rd_data_ref;
  logic               busy;
  logic               done;
  logic               pass_ok;
  logic [CNT_W-1:0]   err_cnt;
  logic [Q_DEPTH-1:0] err_addr;
  logic [D_SIZE-1:0]  err_got;
  logic [D_SIZE-1:0]  err_exp;

  modport master (
    output start, addr_max, passes, rd_data_dut, rd_data_ref,
    input  rd_addr, busy, done, pass_ok, err_cnt, err_addr, err_got, err_exp
  );

  modport slave (
    input  start, addr_max, passes, rd_data_dut, rd_data_ref,
    output rd_addr, busy, done, pass_ok, err_cnt, err_addr, err_got, err_exp
  );
endinterface

// File: rtl/rp_result_checker.sv
// Sweeps DUT RAM and reference memory for N passes, counting word mismatches; RP_CHK_ERRLOG_EN adds first-error capture.
// start->done = passes*(addr_max+1)+RD_LAT+1 cycles; no backpressure, one read issued per cycle while sweeping.
module rp_result_checker #(
  parameter int D_SIZE  = 16,
  parameter int Q_DEPTH = 10,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  rp_result_checker_if.slave  chk
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT);

  state_t             state;
  logic [Q_DEPTH-1:0] rd_addr_q;
  logic [Q_DEPTH-1:0] am_q;
  logic [7:0]         pass_q;
  logic [2:0]         dcnt;
  logic [RD_LAT-1:0]  vld_pipe;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               start_acc;
  logic               mismatch;

  assign start_acc = chk.start && (state == IDLE || state == DONE);
  assign mismatch  = vld_pipe[RD_LAT-1] && (chk.rd_data_dut != chk.rd_data_ref);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr_q <= '0;
      am_q      <= '0;
      pass_q    <= '0;
      dcnt      <= '0;
      vld_pipe  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= (state == ISSUE);

      if (mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (chk.start) begin
            state     <= ISSUE;
            am_q      <= chk.addr_max;
            pass_q    <= (chk.passes == 8'd0) ? 8'd1 : chk.passes;
            rd_addr_q <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        ISSUE: begin
          if (rd_addr_q == am_q) begin
            if (pass_q > 8'd1) begin
              rd_addr_q <= '0;
              pass_q    <= pass_q - 8'd1;
            end else begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // One extra cycle beyond RD_LAT lets the last compare land in err_cnt before done.
          if (dcnt == DRAIN_LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign chk.rd_addr = rd_addr_q;
  assign chk.busy    = busy_q;
  assign chk.done    = done_q;
  assign chk.err_cnt = err_cnt_q;
  assign chk.pass_ok = done_q && (err_cnt_q == '0);

`ifdef RP_CHK_ERRLOG_EN
  logic [Q_DEPTH-1:0] addr_pipe [RD_LAT];
  logic [Q_DEPTH-1:0] err_addr_q;
  logic [D_SIZE-1:0]  err_got_q;
  logic [D_SIZE-1:0]  err_exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
      err_addr_q <= '0;
      err_got_q  <= '0;
      err_exp_q  <= '0;
    end else begin
      addr_pipe[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
      if (start_acc) begin
        err_addr_q <= '0;
        err_got_q  <= '0;
        err_exp_q  <= '0;
      end else if (mismatch && err_cnt_q == '0) begin
        // err_cnt never wraps back to zero, so zero marks "no mismatch yet".
        err_addr_q <= addr_pipe[RD_LAT-1];
        err_got_q  <= chk.rd_data_dut;
        err_exp_q  <= chk.rd_data_ref;
      end
    end
  end

  assign chk.err_addr = err_addr_q;
  assign chk.err_got  = err_got_q;
  assign chk.err_exp  = err_exp_q;
`else
  assign chk.err_addr = '0;
  assign chk.err_got  = '0;
  assign chk.err_exp  = '0;
`endif

endmodule

// File: tb/tb_rp_result_checker.sv
// Runs two checker instances (RD_LAT=1/CNT_W=12 and RD_LAT=4/CNT_W=4) in lockstep over shared memory models.
// Expectations come from a table of hand-derived results and a counting model of the sweep.
module tb_rp_result_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [9:0]  addr_max = '0;
  logic [7:0]  passes = '0;
  logic [15:0] dut_mem [1024];
  logic [15:0] ref_mem [1024];

  rp_result_checker_if #(.D_SIZE(16), .Q_DEPTH(10), .CNT_W(12)) ia ();
  rp_result_checker_if #(.D_SIZE(16), .Q_DEPTH(10), .CNT_W(4))  ib ();

  rp_result_checker #(.D_SIZE(16), .Q_DEPTH(10), .RD_LAT(1), .CNT_W(12)) u_a (.clk(clk), .rst_n(rst_n), .chk(ia));
  rp_result_checker #(.D_SIZE(16), .Q_DEPTH(10), .RD_LAT(4), .CNT_W(4))  u_b (.clk(clk), .rst_n(rst_n), .chk(ib));

  assign ia.start = start;
  assign ib.start = start;
  assign ia.addr_max = addr_max;
  assign ib.addr_max = addr_max;
  assign ia.passes = passes;
  assign ib.passes = passes;

  // Memory read latency models: data valid LAT cycles after the address.
  logic [9:0] sra;
  logic [9:0] srb [4];
  always @(posedge clk) begin
    sra <= ia.rd_addr;
    srb[0] <= ib.rd_addr;
    for (int i = 1; i < 4; i++) srb[i] <= srb[i-1];
  end
  assign ia.rd_data_dut = dut_mem[sra];
  assign ia.rd_data_ref = ref_mem[sra];
  assign ib.rd_data_dut = dut_mem[srb[3]];
  assign ib.rd_data_ref = ref_mem[srb[3]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // mode 0 ideal, 1 flip bit0 at addr 17, 2 all words inverted, 3 sparse random flips
  task automatic fill_mem(input int mode);
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 16'($urandom);
      dut_mem[i] = ref_mem[i];
      case (mode)
        1: if (i == 17) dut_mem[i] = ref_mem[i] ^ 16'h0001;
        2: dut_mem[i] = ~ref_mem[i];
        3: if ($urandom_range(7) == 0) dut_mem[i] = ref_mem[i] ^ (16'h0001 << $urandom_range(15));
        default: ;
      endcase
    end
  endtask

  task automatic run_vec(input int am, input int p, input int rs_at,
                         input int la, input int lb, input int ca, input int cb);
    int first, na, nb, ea, eg, ee;
    first = -1;
    for (int i = 0; i <= am; i++)
      if (first < 0 && dut_mem[i] != ref_mem[i]) first = i;
    addr_max = 10'(am);
    passes = 8'(p);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_rise_a", int'(ia.busy), 1);
    chk("busy_rise_b", int'(ib.busy), 1);
    chk("done_clear_a", int'(ia.done), 0);
    chk("cnt_clear_a", int'(ia.err_cnt), 0);
    chk("cnt_clear_b", int'(ib.err_cnt), 0);
    chk("pass_ok_busy_a", int'(ia.pass_ok), 0);
    na = 0;
    nb = 0;
    for (int n = 1; n <= 3000 && (na == 0 || nb == 0); n++) begin
      @(posedge clk);
      #1;
      start = (n == rs_at);
      if (na == 0 && ia.done) begin
        na = n;
        chk("busy_fall_a", int'(ia.busy), 0);
      end
      if (nb == 0 && ib.done) begin
        nb = n;
        chk("busy_fall_b", int'(ib.busy), 0);
      end
    end
    start = 1'b0;
    chk("latency_a", na, la);
    chk("latency_b", nb, lb);
    chk("err_cnt_a", int'(ia.err_cnt), ca);
    chk("err_cnt_b", int'(ib.err_cnt), cb);
    chk("pass_ok_a", int'(ia.pass_ok), int'(ca == 0));
    chk("pass_ok_b", int'(ib.pass_ok), int'(cb == 0));
`ifdef RP_CHK_ERRLOG_EN
    ea = (first < 0) ? 0 : first;
    eg = (first < 0) ? 0 : int'(dut_mem[first]);
    ee = (first < 0) ? 0 : int'(ref_mem[first]);
`else
    ea = 0;
    eg = 0;
    ee = 0;
`endif
    chk("err_addr_a", int'(ia.err_addr), ea);
    chk("err_got_a", int'(ia.err_got), eg);
    chk("err_exp_a", int'(ia.err_exp), ee);
    chk("err_addr_b", int'(ib.err_addr), ea);
    chk("err_got_b", int'(ib.err_got), eg);
    chk("err_exp_b", int'(ib.err_exp), ee);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy_a"}, int'(ia.busy), 0);
    chk({nm, "_done_a"}, int'(ia.done), 0);
    chk({nm, "_pass_ok_a"}, int'(ia.pass_ok), 0);
    chk({nm, "_err_cnt_a"}, int'(ia.err_cnt), 0);
    chk({nm, "_rd_addr_a"}, int'(ia.rd_addr), 0);
    chk({nm, "_err_addr_a"}, int'(ia.err_addr), 0);
    chk({nm, "_busy_b"}, int'(ib.busy), 0);
    chk({nm, "_err_cnt_b"}, int'(ib.err_cnt), 0);
    chk({nm, "_rd_addr_b"}, int'(ib.rd_addr), 0);
  endtask

  typedef struct {
    int am;
    int p;
    int mode;
    int rs_at;
    int lat_a;
    int lat_b;
    int cnt_a;
    int cnt_b;
  } vec_t;

  initial begin
    vec_t vecs [9];
    int am, p, peff, mism, tot;
    vecs[0] = '{652, 1, 0, 0, 655, 658, 0, 0};     // long ideal sweep
    vecs[1] = '{63, 3, 1, 0, 194, 197, 3, 3};      // one bad word seen every pass
    vecs[2] = '{0, 0, 0, 0, 3, 6, 0, 0};           // single compare, passes 0 -> 1
    vecs[3] = '{31, 1, 2, 0, 34, 37, 32, 15};      // narrow counter saturates
    vecs[4] = '{31, 2, 2, 0, 66, 69, 64, 15};      // and stays saturated
    vecs[5] = '{0, 2, 2, 0, 4, 7, 2, 2};
    vecs[6] = '{5, 0, 1, 0, 8, 11, 0, 0};          // bad word outside the swept range
    vecs[7] = '{1023, 1, 1, 0, 1026, 1029, 1, 1};  // full address range
    vecs[8] = '{652, 1, 0, 9, 655, 658, 0, 0};     // extra start mid-sweep is ignored

    fill_mem(0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      fill_mem(vecs[k].mode);
      run_vec(vecs[k].am, vecs[k].p, vecs[k].rs_at,
              vecs[k].lat_a, vecs[k].lat_b, vecs[k].cnt_a, vecs[k].cnt_b);
    end

    // Reset in the middle of a sweep with errors already counted.
    fill_mem(2);
    addr_max = 10'd200;
    passes = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midreset_async");
    repeat (2) @(posedge clk);
    #1 chk_zero("midreset_hold");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    fill_mem(0);
    run_vec(652, 1, 0, 655, 658, 0, 0);

    // Random sweeps checked against a counting model of the whole run.
    for (int r = 0; r < 20; r++) begin
      fill_mem(3);
      am = int'($urandom_range(120));
      p = int'($urandom_range(4));
      peff = (p == 0) ? 1 : p;
      mism = 0;
      for (int i = 0; i <= am; i++) if (dut_mem[i] != ref_mem[i]) mism++;
      tot = peff * mism;
      run_vec(am, p, 0, peff * (am + 1) + 2, peff * (am + 1) + 5,
              (tot > 4095) ? 4095 : tot, (tot > 15) ? 15 : tot);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
